// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS ID-stage branch resolver
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RES  = 2'd2
    } br_state_t;

    localparam logic       FWD_REGFILE = 1'b0;
    localparam logic       FWD_EXMEM   = 1'b1;
    localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage

// File: rtl/mips_branch_resolver_if.sv
// rtl/mips_branch_resolver_if.sv - ID/EX/MEM inputs and branch control outputs of the resolver
interface mips_branch_resolver_if #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
);
    logic              id_valid;
    logic              id_is_beq;
    logic              id_is_bne;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [ADDR_W-1:0] id_pc_plus4;
    logic [31:0]       id_imm;
    logic              cmp_eq;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_W-1:0]  ex_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic [REG_W-1:0]  mem_rd;
    logic              stall;
    logic              fwd_a_sel;
    logic              fwd_b_sel;
    logic              pc_redirect_valid;
    logic [ADDR_W-1:0] pc_redirect_target;
    logic              flush_if_id;

    modport master (
        output id_valid, id_is_beq, id_is_bne, id_rs, id_rt, id_pc_plus4, id_imm, cmp_eq,
        output ex_reg_write, ex_mem_read, ex_rd, mem_reg_write, mem_mem_read, mem_rd,
        input  stall, fwd_a_sel, fwd_b_sel, pc_redirect_valid, pc_redirect_target, flush_if_id
    );

    modport slave (
        input  id_valid, id_is_beq, id_is_bne, id_rs, id_rt, id_pc_plus4, id_imm, cmp_eq,
        input  ex_reg_write, ex_mem_read, ex_rd, mem_reg_write, mem_mem_read, mem_rd,
        output stall, fwd_a_sel, fwd_b_sel, pc_redirect_valid, pc_redirect_target, flush_if_id
    );

endinterface

// File: rtl/mips_branch_hazard_detect.sv
// rtl/mips_branch_hazard_detect.sv - stall-cycle need and comparator forwarding selects for a branch
module mips_branch_hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_mem_reg_write,
    input  logic             i_mem_mem_read,
    input  logic [REG_W-1:0] i_mem_rd,
    output logic [1:0]       o_need,
    output logic             o_fwd_a_sel,
    output logic             o_fwd_b_sel
);
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_mem_alu;

    assign w_ex_hit  = (i_ex_rd != REG_W'(REG_ZERO)) && ((i_ex_rd == i_rs) || (i_ex_rd == i_rt));
    assign w_mem_hit = (i_mem_rd != REG_W'(REG_ZERO)) && ((i_mem_rd == i_rs) || (i_mem_rd == i_rt));

    // A load in EX needs two cycles to reach the comparator; EX wins over MEM.
    always_comb begin
        o_need = 2'd0;
        if (i_ex_mem_read && w_ex_hit) begin
            o_need = 2'd2;
        end else if ((i_ex_reg_write && w_ex_hit) || (i_mem_mem_read && w_mem_hit)) begin
            o_need = 2'd1;
        end
    end

    assign w_mem_alu   = i_mem_reg_write && !i_mem_mem_read && (i_mem_rd != REG_W'(REG_ZERO));
    assign o_fwd_a_sel = (w_mem_alu && (i_mem_rd == i_rs)) ? FWD_EXMEM : FWD_REGFILE;
    assign o_fwd_b_sel = (w_mem_alu && (i_mem_rd == i_rt)) ? FWD_EXMEM : FWD_REGFILE;

endmodule

// File: rtl/mips_branch_resolver.sv
// rtl/mips_branch_resolver.sv - ID-stage BEQ/BNE stall, forward and redirect control; BRANCH_STATS_EN adds counters
module mips_branch_resolver
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef BRANCH_STATS_EN
    output logic [15:0]           br_taken_cnt,
    output logic [15:0]           br_stall_cnt,
`endif
    mips_branch_resolver_if.slave bus
);
    br_state_t   r_state;
    br_state_t   w_next;
    logic        w_br;
    logic        w_stall;
    logic        w_resolve;
    logic        w_taken;
    logic [1:0]  w_need;
    logic        w_fwd_a;
    logic        w_fwd_b;
    logic [31:0] w_offset;

    mips_branch_hazard_detect #(.REG_W(REG_W)) u_hazard (
        .i_rs            (bus.id_rs),
        .i_rt            (bus.id_rt),
        .i_ex_reg_write  (bus.ex_reg_write),
        .i_ex_mem_read   (bus.ex_mem_read),
        .i_ex_rd         (bus.ex_rd),
        .i_mem_reg_write (bus.mem_reg_write),
        .i_mem_mem_read  (bus.mem_mem_read),
        .i_mem_rd        (bus.mem_rd),
        .o_need          (w_need),
        .o_fwd_a_sel     (w_fwd_a),
        .o_fwd_b_sel     (w_fwd_b)
    );

    assign w_br = bus.id_valid && (bus.id_is_beq || bus.id_is_bne);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Losing the branch while waiting abandons it without a resolve.
    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_resolve = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_br) begin
                    if (w_need == 2'd2) begin
                        w_stall = 1'b1;
                        w_next  = WAIT;
                    end else if (w_need == 2'd1) begin
                        w_stall = 1'b1;
                        w_next  = RES;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (w_br) begin
                    w_stall = 1'b1;
                    w_next  = RES;
                end else begin
                    w_next = IDLE;
                end
            end
            RES: begin
                w_resolve = w_br;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // BEQ takes precedence when both opcode flags are set.
    assign w_taken  = bus.id_is_beq ? bus.cmp_eq : !bus.cmp_eq;
    assign w_offset = bus.id_imm << 2;

    assign bus.stall              = w_stall;
    assign bus.pc_redirect_valid  = w_resolve && w_taken;
    assign bus.flush_if_id        = w_resolve && w_taken;
    assign bus.fwd_a_sel          = w_resolve ? w_fwd_a : FWD_REGFILE;
    assign bus.fwd_b_sel          = w_resolve ? w_fwd_b : FWD_REGFILE;
    assign bus.pc_redirect_target = w_br ? (bus.id_pc_plus4 + w_offset[ADDR_W-1:0]) : '0;

`ifdef BRANCH_STATS_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_resolve && w_taken && (r_taken_cnt != 16'hFFFF)) begin
                r_taken_cnt <= r_taken_cnt + 16'd1;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign br_taken_cnt = r_taken_cnt;
    assign br_stall_cnt = r_stall_cnt;
`endif

endmodule
